rr_arbiter4: RTL

Four-requester round-robin arbiter that shares one resource among four masters. It issues a registered one-hot grant and a one-cold active-low mirror of that grant. A hold-time limit preempts an owner that keeps the resource while others wait. It sits between the requesting masters and the shared resource's select/enable lines.

---
 rtl/rr_arbiter4.sv | 112 +++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant,
// an active-low grant mirror, and a hold-time limit that preempts a lingering owner.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [3:0] gnt_n,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t     state, state_nx;
    logic [3:0] gnt_nx;
    logic [1:0] gnt_id_nx;
    logic [1:0] last, last_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic       preempt_nx;

    logic [3:0] cand;
    logic       arb;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        last_nx    = last;
        hold_nx    = hold_cnt;
        preempt_nx = 1'b0;
        cand       = req;
        arb        = 1'b0;
        found      = 1'b0;
        win        = '0;
        idx        = '0;

        case (state)
            IDLE: arb = 1'b1;
            OWNED: begin
                if (!req[gnt_id]) begin
                    arb = 1'b1;
                end else if ((req & ~gnt) != '0 && hold_cnt == HOLD_LIM) begin
                    // owner is masked out so the preempt always lands on a competitor
                    arb        = 1'b1;
                    preempt_nx = 1'b1;
                    cand       = req & ~gnt;
                end else if (hold_cnt < HOLD_LIM) begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            default: arb = 1'b1;
        endcase

        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        if (arb) begin
            if (found) begin
                state_nx  = OWNED;
                gnt_nx    = 4'b0001 << win;
                gnt_id_nx = win;
                last_nx   = win;
                hold_nx   = 8'd1;
            end else begin
                state_nx   = IDLE;
                gnt_nx     = '0;
                gnt_id_nx  = '0;
                hold_nx    = '0;
                preempt_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            last     <= 2'd3;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            gnt_id   <= gnt_id_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
            preempt  <= preempt_nx;
        end
    end

    assign gnt_n = ~gnt;
    assign busy  = |gnt;

endmodule
